// File: rtl/tx_fifo_pkg.sv
// tx_fifo_pkg
// Shared constants and helpers for the tx_sync_fifo slice.
//   RD_MODE_FWFT / RD_MODE_STD : read-mode encodings, compared against READ_MODE
//   RST_BUSY_CYCLES            : cycles the busy flags stay high after reset falls
//   clog2()                    : elaboration-time ceiling log2
package tx_fifo_pkg;

  // Read modes are kept as packed ASCII so a plain "fwft"/"std" string
  // literal given at instantiation compares equal to these constants.
  localparam logic [31:0] RD_MODE_FWFT = "fwft";
  localparam logic [31:0] RD_MODE_STD  = "std";

  localparam int RST_BUSY_CYCLES = 2;

  // Ceiling log2; clog2(1) is 0, clog2(16) is 4, clog2(17) is 5.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/tx_fifo_ram.sv
// tx_fifo_ram
// Simple dual-port RAM: one write port and one synchronous read port on a
// single clock. Contents are never cleared; only the read register resets.
//   i_clk     : clock
//   i_rdRst   : synchronous clear of the read-data register
//   i_wrEn    : write strobe
//   i_wrAddr  : write address
//   i_wrData  : write data
//   i_rdEn    : read strobe, loads o_rdData at the clock edge
//   i_rdAddr  : read address
//   o_rdData  : registered read data, holds when i_rdEn is low
module tx_fifo_ram
  import tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                           i_clk,
  input  logic                           i_rdRst,
  input  logic                           i_wrEn,
  input  logic [clog2(FIFO_DEPTH)-1:0]   i_wrAddr,
  input  logic [DATA_WIDTH-1:0]          i_wrData,
  input  logic                           i_rdEn,
  input  logic [clog2(FIFO_DEPTH)-1:0]   i_rdAddr,
  output logic [DATA_WIDTH-1:0]          o_rdData
);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdData;

  // Write port; no reset so the array maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  // Synchronous read port with a clearable output register, which doubles
  // as the FIFO output register in both read modes.
  always_ff @(posedge i_clk) begin
    if (i_rdRst) begin
      r_rdData <= '0;
    end else if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/tx_sync_fifo.sv
// tx_sync_fifo
// Single-clock FIFO with real storage, registered flags, occupancy counts,
// overflow/underflow/ack pulses and reset-busy handshaking. Supports
// first-word-fall-through ("fwft") and standard ("std") read modes.
//   wr_clk, rst                : clock and synchronous active-high reset
//   din, wr_en                 : write side
//   rd_en                      : read request (fwft: pop the head word)
//   dout, data_valid           : read side
//   empty/full, almost_*/prog_*: registered occupancy flags
//   overflow/underflow/wr_ack  : one-cycle pulses for last cycle's requests
//   wr_data_count/rd_data_count: occupancy, including the fwft output word
//   wr_rst_busy/rd_rst_busy    : high during reset and RST_BUSY_CYCLES after
module tx_sync_fifo
  import tx_fifo_pkg::*;
#(
  parameter int          DATA_WIDTH        = 32,
  parameter int          FIFO_DEPTH        = 64,
  parameter logic [31:0] READ_MODE         = RD_MODE_FWFT,
  parameter int          PROG_FULL_THRESH  = 10,
  parameter int          PROG_EMPTY_THRESH = 10,
  parameter int          COUNT_WIDTH       = 7
) (
  input  logic                    wr_clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    wr_en,
  input  logic                    rd_en,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    data_valid,
  output logic                    empty,
  output logic                    full,
  output logic                    almost_empty,
  output logic                    almost_full,
  output logic                    prog_empty,
  output logic                    prog_full,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    wr_ack,
  output logic [COUNT_WIDTH-1:0]  wr_data_count,
  output logic [COUNT_WIDTH-1:0]  rd_data_count,
  output logic                    wr_rst_busy,
  output logic                    rd_rst_busy
);

  localparam int AW     = clog2(FIFO_DEPTH);
  localparam int BUSY_W = clog2(RST_BUSY_CYCLES + 1);
  localparam bit IS_FWFT = (READ_MODE == RD_MODE_FWFT);

  localparam logic [AW-1:0]          PTR_ONE    = AW'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE    = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_DEPTH  = COUNT_WIDTH'(FIFO_DEPTH);
  localparam logic [COUNT_WIDTH-1:0] CNT_AFULL  = COUNT_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_PFULL  = COUNT_WIDTH'(PROG_FULL_THRESH);
  localparam logic [COUNT_WIDTH-1:0] CNT_PEMPTY = COUNT_WIDTH'(PROG_EMPTY_THRESH);
  localparam logic [BUSY_W-1:0]      BUSY_INIT  = BUSY_W'(RST_BUSY_CYCLES);
  localparam logic [BUSY_W-1:0]      BUSY_ONE   = BUSY_W'(1);

  logic [AW-1:0]          r_wrPtr;
  logic [AW-1:0]          r_rdPtr;
  logic [COUNT_WIDTH-1:0] r_occ;
  logic [COUNT_WIDTH-1:0] r_ramCount;
  logic                   r_outValid;
  logic                   r_empty;
  logic                   r_full;
  logic                   r_almostEmpty;
  logic                   r_almostFull;
  logic                   r_progEmpty;
  logic                   r_progFull;
  logic                   r_overflow;
  logic                   r_underflow;
  logic                   r_wrAck;
  logic [BUSY_W-1:0]      r_busyCnt;
  logic                   r_busy;

  logic                   w_wrAcc;
  logic                   w_rdAcc;
  logic                   w_ramRd;
  logic                   w_outValidNext;
  logic                   w_emptyNext;
  logic [COUNT_WIDTH-1:0] w_occNext;
  logic [COUNT_WIDTH-1:0] w_ramCountNext;
  logic [DATA_WIDTH-1:0]  w_ramData;

  // Acceptance uses the registered flags; a rejected request changes nothing
  // except the error pulse on the following cycle.
  assign w_wrAcc = wr_en & ~r_full  & ~r_busy;
  assign w_rdAcc = rd_en & ~r_empty & ~r_busy;

  // RAM read scheduling. In std mode a read goes straight to the RAM. In fwft
  // mode the RAM read register is the output register: it is refilled
  // whenever it is empty or being popped and the RAM still holds a word, so
  // back-to-back pops run at full rate. r_outValid tracks "output register
  // holds a word" in fwft and the single-cycle read strobe in std.
  always_comb begin
    w_ramRd        = w_rdAcc;
    w_outValidNext = w_rdAcc;
    if (IS_FWFT) begin
      w_ramRd = (r_ramCount != '0) & (~r_outValid | w_rdAcc);
      if (w_ramRd) begin
        w_outValidNext = 1'b1;
      end else if (w_rdAcc) begin
        w_outValidNext = 1'b0;
      end else begin
        w_outValidNext = r_outValid;
      end
    end
  end

  // Next-state occupancy (words anywhere in the FIFO) and RAM-only word
  // count; the two differ only by the fwft output register.
  always_comb begin
    w_occNext = r_occ;
    if (w_wrAcc & ~w_rdAcc) begin
      w_occNext = r_occ + CNT_ONE;
    end else if (~w_wrAcc & w_rdAcc) begin
      w_occNext = r_occ - CNT_ONE;
    end

    w_ramCountNext = r_ramCount;
    if (w_wrAcc & ~w_ramRd) begin
      w_ramCountNext = r_ramCount + CNT_ONE;
    end else if (~w_wrAcc & w_ramRd) begin
      w_ramCountNext = r_ramCount - CNT_ONE;
    end
  end

  // In fwft mode the FIFO is only readable once a word sits in the output
  // register, so empty lags occupancy by the prefetch stage.
  assign w_emptyNext = IS_FWFT ? ~w_outValidNext : (w_occNext == '0);

  // Reset-busy sequencer: busy holds through reset and for RST_BUSY_CYCLES
  // edges after reset is released.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      r_busyCnt <= BUSY_INIT;
      r_busy    <= 1'b1;
    end else if (r_busyCnt != '0) begin
      r_busyCnt <= r_busyCnt - BUSY_ONE;
      r_busy    <= (r_busyCnt != BUSY_ONE);
    end
  end

  // Pointers, counts and flags. Flags are registered from next-state values
  // so they change on the same edge as the counts.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      r_wrPtr       <= '0;
      r_rdPtr       <= '0;
      r_occ         <= '0;
      r_ramCount    <= '0;
      r_outValid    <= 1'b0;
      r_empty       <= 1'b1;
      r_full        <= 1'b0;
      r_almostEmpty <= 1'b1;
      r_almostFull  <= 1'b0;
      r_progEmpty   <= 1'b1;
      r_progFull    <= 1'b0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
      r_wrAck       <= 1'b0;
    end else begin
      if (w_wrAcc) begin
        r_wrPtr <= r_wrPtr + PTR_ONE;
      end
      if (w_ramRd) begin
        r_rdPtr <= r_rdPtr + PTR_ONE;
      end
      r_occ         <= w_occNext;
      r_ramCount    <= w_ramCountNext;
      r_outValid    <= w_outValidNext;
      r_empty       <= w_emptyNext;
      r_full        <= (w_occNext == CNT_DEPTH);
      r_almostEmpty <= (w_occNext <= CNT_ONE);
      r_almostFull  <= (w_occNext >= CNT_AFULL);
      r_progEmpty   <= (w_occNext <= CNT_PEMPTY);
      r_progFull    <= (w_occNext >= CNT_PFULL);
      r_overflow    <= wr_en & ~w_wrAcc;
      r_underflow   <= rd_en & ~w_rdAcc;
      r_wrAck       <= w_wrAcc;
    end
  end

  tx_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_ram (
    .i_clk    (wr_clk),
    .i_rdRst  (rst),
    .i_wrEn   (w_wrAcc),
    .i_wrAddr (r_wrPtr),
    .i_wrData (din),
    .i_rdEn   (w_ramRd),
    .i_rdAddr (r_rdPtr),
    .o_rdData (w_ramData)
  );

  assign dout          = w_ramData;
  assign data_valid    = r_outValid;
  assign empty         = r_empty;
  assign full          = r_full;
  assign almost_empty  = r_almostEmpty;
  assign almost_full   = r_almostFull;
  assign prog_empty    = r_progEmpty;
  assign prog_full     = r_progFull;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;
  assign wr_ack        = r_wrAck;
  assign wr_data_count = r_occ;
  assign rd_data_count = r_occ;
  assign wr_rst_busy   = r_busy;
  assign rd_rst_busy   = r_busy;

endmodule

// File: tb/tb_tx_sync_fifo.sv
// tb_tx_sync_fifo
// Drives a std-mode instance (depth 16, prog thresholds 12/3) and an
// fwft-mode instance (depth 16, thresholds 10/10) from one clock. Accepted
// writes push onto per-instance scoreboards; words are popped and compared
// when the instance presents them.
module tb_tx_sync_fifo;
  import tx_fifo_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // std instance signals
  logic       rstS, wrEnS, rdEnS;
  logic [7:0] dinS, doutS;
  logic       dvS, emptyS, fullS, aeS, afS, peS, pfS, ovfS, udfS, ackS, wbS, rbS;
  logic [4:0] wcS, rcS;

  // fwft instance signals
  logic       rstF, wrEnF, rdEnF;
  logic [7:0] dinF, doutF;
  logic       dvF, emptyF, fullF, aeF, afF, peF, pfF, ovfF, udfF, ackF, wbF, rbF;
  logic [4:0] wcF, rcF;

  tx_sync_fifo #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .READ_MODE(RD_MODE_STD),
    .PROG_FULL_THRESH(12), .PROG_EMPTY_THRESH(3), .COUNT_WIDTH(5)
  ) dutStd (
    .wr_clk(clk), .rst(rstS), .din(dinS), .wr_en(wrEnS), .rd_en(rdEnS),
    .dout(doutS), .data_valid(dvS), .empty(emptyS), .full(fullS),
    .almost_empty(aeS), .almost_full(afS), .prog_empty(peS), .prog_full(pfS),
    .overflow(ovfS), .underflow(udfS), .wr_ack(ackS),
    .wr_data_count(wcS), .rd_data_count(rcS),
    .wr_rst_busy(wbS), .rd_rst_busy(rbS)
  );

  tx_sync_fifo #(
    .DATA_WIDTH(8), .FIFO_DEPTH(16), .READ_MODE(RD_MODE_FWFT),
    .PROG_FULL_THRESH(10), .PROG_EMPTY_THRESH(10), .COUNT_WIDTH(5)
  ) dutFwft (
    .wr_clk(clk), .rst(rstF), .din(dinF), .wr_en(wrEnF), .rd_en(rdEnF),
    .dout(doutF), .data_valid(dvF), .empty(emptyF), .full(fullF),
    .almost_empty(aeF), .almost_full(afF), .prog_empty(peF), .prog_full(pfF),
    .overflow(ovfF), .underflow(udfF), .wr_ack(ackF),
    .wr_data_count(wcF), .rd_data_count(rcF),
    .wr_rst_busy(wbF), .rd_rst_busy(rbF)
  );

  int checksDone   = 0;
  int checksPassed = 0;

  // Scoreboards and reference state
  logic [7:0] expS[$];
  logic [7:0] expF[$];
  int occS  = 0;
  int occF  = 0;
  int ramF  = 0;
  bit headF = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checksDone++;
    if (observed === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkResetStd(input string tag);
    checkOutput({tag, "_dout"}, doutS, 0);
    checkOutput({tag, "_dv"}, dvS, 0);
    checkOutput({tag, "_empty"}, emptyS, 1);
    checkOutput({tag, "_ae"}, aeS, 1);
    checkOutput({tag, "_pe"}, peS, 1);
    checkOutput({tag, "_full"}, fullS, 0);
    checkOutput({tag, "_af"}, afS, 0);
    checkOutput({tag, "_pf"}, pfS, 0);
    checkOutput({tag, "_wcount"}, wcS, 0);
    checkOutput({tag, "_rcount"}, rcS, 0);
    checkOutput({tag, "_ovf"}, ovfS, 0);
    checkOutput({tag, "_udf"}, udfS, 0);
    checkOutput({tag, "_ack"}, ackS, 0);
    checkOutput({tag, "_wbusy"}, wbS, 1);
    checkOutput({tag, "_rbusy"}, rbS, 1);
  endtask

  task automatic checkResetFwft(input string tag);
    checkOutput({tag, "_dout"}, doutF, 0);
    checkOutput({tag, "_dv"}, dvF, 0);
    checkOutput({tag, "_empty"}, emptyF, 1);
    checkOutput({tag, "_full"}, fullF, 0);
    checkOutput({tag, "_pf"}, pfF, 0);
    checkOutput({tag, "_pe"}, peF, 1);
    checkOutput({tag, "_count"}, wcF, 0);
    checkOutput({tag, "_wbusy"}, wbF, 1);
    checkOutput({tag, "_rbusy"}, rbF, 1);
  endtask

  // One std-mode cycle: drive, push accepted writes, then check the cycle's
  // results (read data popped from the scoreboard when data_valid is due).
  task automatic applyStimulus(input logic wr, input logic rd, input logic [7:0] d);
    bit wAcc, rAcc;
    logic [7:0] want;
    wAcc  = wr && (occS < 16);
    rAcc  = rd && (occS > 0);
    wrEnS = wr; rdEnS = rd; dinS = d;
    if (wAcc) expS.push_back(d);
    occS = occS + int'(wAcc) - int'(rAcc);
    tick();
    wrEnS = 1'b0; rdEnS = 1'b0;
    checkOutput("std_count", wcS, occS);
    checkOutput("std_rdcount", rcS, occS);
    checkOutput("std_ack", ackS, wAcc);
    checkOutput("std_ovf", ovfS, wr && !wAcc);
    checkOutput("std_udf", udfS, rd && !rAcc);
    checkOutput("std_dv", dvS, rAcc);
    checkOutput("std_full", fullS, occS == 16);
    checkOutput("std_empty", emptyS, occS == 0);
    checkOutput("std_af", afS, occS >= 15);
    checkOutput("std_ae", aeS, occS <= 1);
    checkOutput("std_pf", pfS, occS >= 12);
    checkOutput("std_pe", peS, occS <= 3);
    if (rAcc) begin
      if (expS.size() == 0) begin
        checkOutput("std_sb_underrun", 1, 0);
      end else begin
        want = expS.pop_front();
        checkOutput("std_dout", doutS, want);
      end
    end
  endtask

  // One fwft-mode cycle: the head word must already be on dout before it is
  // popped; the reference tracks when a written word reaches the output.
  task automatic applyFwft(input logic wr, input logic rd, input logic [7:0] d);
    bit wAcc, pop, pre;
    logic [7:0] want;
    checkOutput("fwft_empty", emptyF, !headF);
    checkOutput("fwft_dv", dvF, headF);
    if (headF) begin
      want = expF[0];
      checkOutput("fwft_dout", doutF, want);
    end
    pop  = rd && headF;
    wAcc = wr && (occF < 16);
    pre  = (ramF > 0) && (!headF || pop);
    wrEnF = wr; rdEnF = rd; dinF = d;
    if (pop) void'(expF.pop_front());
    if (wAcc) expF.push_back(d);
    ramF  = ramF + int'(wAcc) - int'(pre);
    headF = pre ? 1'b1 : (pop ? 1'b0 : headF);
    occF  = occF + int'(wAcc) - int'(pop);
    tick();
    wrEnF = 1'b0; rdEnF = 1'b0;
    checkOutput("fwft_count", wcF, occF);
    checkOutput("fwft_ack", ackF, wAcc);
    checkOutput("fwft_ovf", ovfF, wr && !wAcc);
    checkOutput("fwft_udf", udfF, rd && !pop);
    checkOutput("fwft_full", fullF, occF == 16);
    checkOutput("fwft_af", afF, occF >= 15);
    checkOutput("fwft_ae", aeF, occF <= 1);
    checkOutput("fwft_pf", pfF, occF >= 10);
    checkOutput("fwft_pe", peF, occF <= 10);
  endtask

  initial begin
    rstS = 1'b1; wrEnS = 1'b0; rdEnS = 1'b0; dinS = '0;
    rstF = 1'b1; wrEnF = 1'b0; rdEnF = 1'b0; dinF = '0;

    // Reset both instances for one edge and watch the busy window.
    tick();
    checkResetStd("rst_std");
    checkResetFwft("rst_fwft");
    rstS = 1'b0; rstF = 1'b0;
    tick();
    checkOutput("busy1_std", wbS, 1);
    checkOutput("busy1_fwft", rbF, 1);
    tick();
    checkOutput("busy2_std", rbS, 0);
    checkOutput("busy2_fwft", wbF, 0);

    // std: fill to full, overflow, full-with-read, then drain in order.
    $display("[TB] std fill/overflow/drain");
    for (int i = 1; i <= 16; i++) applyStimulus(1'b1, 1'b0, 8'(i));
    applyStimulus(1'b1, 1'b0, 8'hAA);
    applyStimulus(1'b1, 1'b1, 8'hBB);
    for (int i = 0; i < 15; i++) applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b1, 1'b1, 8'hC3);
    applyStimulus(1'b0, 1'b1, 8'h00);

    // std: programmable thresholds and steady simultaneous traffic.
    $display("[TB] std thresholds");
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 8'(8'h30 + i));
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 8'(8'h50 + i));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h00);

    // std: reset mid-stream at occupancy 9, then a write during busy.
    $display("[TB] std mid-stream reset");
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 8'(8'h70 + i));
    applyStimulus(1'b0, 1'b1, 8'h00);
    checkOutput("std_pre_rst_count", wcS, 9);
    rstS = 1'b1;
    tick();
    checkResetStd("mid_rst_std");
    expS.delete();
    occS = 0;
    rstS = 1'b0; wrEnS = 1'b1; dinS = 8'h77;
    tick();
    wrEnS = 1'b0;
    checkOutput("busy_wr_ovf", ovfS, 1);
    checkOutput("busy_wr_ack", ackS, 0);
    checkOutput("busy_wr_count", wcS, 0);
    checkOutput("busy_wr_busy", wbS, 1);
    tick();
    checkOutput("busy_end", wbS, 0);
    applyStimulus(1'b1, 1'b0, 8'h33);
    applyStimulus(1'b0, 1'b1, 8'h00);

    // fwft: single write latency and underflow on an empty FIFO.
    $display("[TB] fwft latency/underflow");
    applyFwft(1'b1, 1'b0, 8'h5C);
    applyFwft(1'b0, 1'b0, 8'h00);
    applyFwft(1'b0, 1'b1, 8'h00);
    applyFwft(1'b0, 1'b1, 8'h00);
    applyFwft(1'b0, 1'b0, 8'h00);

    // fwft: reach occupancy 8, then sustained full-rate read+write.
    $display("[TB] fwft streaming");
    for (int i = 0; i < 8; i++) applyFwft(1'b1, 1'b0, 8'(8'h80 + i));
    applyFwft(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 112; i++) applyFwft(1'b1, 1'b1, 8'(i * 7 + 3));
    applyFwft(1'b0, 1'b0, 8'h00);

    // fwft: fill to full and check overflow, then reset mid-stream.
    for (int i = 0; i < 9; i++) applyFwft(1'b1, 1'b0, 8'(8'hE0 + i));
    applyFwft(1'b1, 1'b0, 8'hFF);
    rstF = 1'b1;
    tick();
    checkResetFwft("mid_rst_fwft");
    rstF = 1'b0;
    expF.delete();
    occF = 0; ramF = 0; headF = 1'b0;
    tick();
    tick();
    applyFwft(1'b1, 1'b0, 8'h42);
    applyFwft(1'b0, 1'b0, 8'h00);
    applyFwft(1'b0, 1'b1, 8'h00);
    applyFwft(1'b0, 1'b0, 8'h00);

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end

endmodule
